// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cell-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_CLIENTS = 4;
  localparam int unsigned SEL_W       = 2;

  localparam logic [SEL_W-1:0] CLI_DISPLAY = 2'd0;
  localparam logic [SEL_W-1:0] CLI_ENGINE  = 2'd1;
  localparam logic [SEL_W-1:0] CLI_LOADER  = 2'd2;
  localparam logic [SEL_W-1:0] CLI_HOST    = 2'd3;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Request/grant bundle between memory clients and the arbiter.
interface mem_access_arbiter_if;
  import mem_arb_pkg::*;

  logic [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] grant;
  logic [SEL_W-1:0]       select;
  logic                   busy;
  logic                   hold_expired;

  modport master (output req, input grant, select, busy, hold_expired);
  modport slave  (input req, output grant, select, busy, hold_expired);

endinterface

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set candidate after the last owner.
module rr_pick_4
  import mem_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] cand,
  input  logic [SEL_W-1:0]       last,
  output logic                   valid_c,
  output logic [SEL_W-1:0]       idx_c
);

  logic [SEL_W-1:0] pos;

  // Search last+1 .. last+4 (wrapping), so the last owner is tried last.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = last;
    pos     = last;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      pos = last + SEL_W'(k);
      if (!valid_c && cand[pos]) begin
        valid_c = 1'b1;
        idx_c   = pos;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter for the shared cell-memory port with a hold timer
// that preempts an owner after MAX_HOLD cycles under contention.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_arbiter_if.slave  bus
);

  localparam int unsigned      CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e             state_q, state_d;
  logic [SEL_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]       select_q, select_d;
  logic                   busy_q, busy_d;
  logic                   hold_exp_q, hold_exp_d;

  logic [NUM_CLIENTS-1:0] cand_c;
  logic                   pick_valid_c;
  logic [SEL_W-1:0]       pick_idx_c;

  // While owned, the owner is excluded so a pick always names a different client.
  assign cand_c = (state_q == ARB_OWNED) ? (bus.req & ~onehot(last_q)) : bus.req;

  rr_pick_4 u_pick (
    .cand    (cand_c),
    .last    (last_q),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      last_q     <= SEL_W'(NUM_CLIENTS - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      select_q   <= '0;
      busy_q     <= 1'b0;
      hold_exp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      select_q   <= select_d;
      busy_q     <= busy_d;
      hold_exp_q <= hold_exp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    select_d   = select_q;
    hold_exp_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_c) begin
          state_d  = ARB_OWNED;
          grant_d  = onehot(pick_idx_c);
          select_d = pick_idx_c;
          last_d   = pick_idx_c;
          cnt_d    = '0;
        end
      end
      ARB_OWNED: begin
        if (!bus.req[last_q]) begin
          // Release takes priority over preemption, so no expiry pulse here.
          if (pick_valid_c) begin
            grant_d  = onehot(pick_idx_c);
            select_d = pick_idx_c;
            last_d   = pick_idx_c;
            cnt_d    = '0;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (cnt_q == HOLD_LAST) begin
          if (pick_valid_c) begin
            grant_d    = onehot(pick_idx_c);
            select_d   = pick_idx_c;
            last_d     = pick_idx_c;
            cnt_d      = '0;
            hold_exp_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = |grant_d;
  end

  assign bus.grant        = grant_q;
  assign bus.select       = select_q;
  assign bus.busy         = busy_q;
  assign bus.hold_expired = hold_exp_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with MAX_HOLD=4.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   failed;
  int   seq [5] = '{0, 1, 2, 3, 0};

  mem_access_arbiter_if bus ();

  mem_access_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic h);
    chk({tag, ".grant"},  bus.grant, g);
    chk({tag, ".select"}, {2'b00, bus.select}, {2'b00, s});
    chk({tag, ".busy"},   {3'b000, bus.busy}, {3'b000, b});
    chk({tag, ".hexp"},   {3'b000, bus.hold_expired}, {3'b000, h});
  endtask

  // Sub-period reset pulse; outputs must clear before the next clock edge.
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    failed  = 0;
    clk     = 1'b0;
    rst_n   = 1'b1;
    bus.req = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, then release; select holds the last owner.
    bus.req = 4'b0100;
    tick();
    chk_all("t1.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_all("t1.release", 4'b0000, 2'd2, 1'b0, 1'b0);

    // All four request after reset; each holds two cycles, rotation 0,1,2,3,0.
    rst_pulse("t2.reset");
    bus.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("t2.own%0d.c1", i), 4'b0001 << seq[i], 2'(seq[i]), 1'b1, 1'b0);
      tick();
      chk_all($sformatf("t2.own%0d.c2", i), 4'b0001 << seq[i], 2'(seq[i]), 1'b1, 1'b0);
      bus.req[seq[i]] = 1'b0;
      if (seq[i] == 3) bus.req[0] = 1'b1;
      tick();
    end
    chk_all("t2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold-timer preemption: client 1 for exactly 4 cycles, then client 3.
    bus.req = 4'b0010;
    tick();
    chk_all("t3.c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_all("t3.c2", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b1010;
    tick();
    chk_all("t3.c3", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_all("t3.c4", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_all("t3.preempt", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick();
    chk_all("t3.pulse_end", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.req = 4'b0010;
    tick();
    chk_all("t3.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_all("t3.idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Lone requester keeps the grant; counter saturates so a late rival preempts at once.
    bus.req = 4'b0100;
    tick();
    chk_all("t4.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all($sformatf("t4.hold%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    bus.req = 4'b0101;
    tick();
    chk_all("t4.sat_preempt", 4'b0001, 2'd0, 1'b1, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_all("t4.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner releases while its counter is at MAX_HOLD-1: plain handover, no pulse.
    bus.req = 4'b0100;
    tick();
    chk_all("t5.c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0101;
    tick();
    chk_all("t5.c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk_all("t5.c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk_all("t5.c4", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0001;
    tick();
    chk_all("t5.handover", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_all("t5.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-grant, then re-request; last pointer must become 1.
    bus.req = 4'b0100;
    tick();
    chk_all("t6.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst_pulse("t6.async");
    bus.req = 4'b0010;
    tick();
    chk_all("t6.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_all("t6.idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    bus.req = 4'b1111;
    tick();
    chk_all("t6.last_ptr", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Round-robin arbiter for the shared cell-memory port.
- Up to four clients (e.g. display scan, life engine, pattern loader, host access) raise requests.
- The block grants one client at a time and drives the 2-bit select of the downstream 4:1 address/data mux (WIDTH-bit buses).
- A hold timer bounds a client's tenure under contention so no client starves.

Parameters:
- MAX_HOLD, 16, max consecutive granted cycles for one client while another client is requesting; legal range 1..255.
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-client request, bit i = client i.
- grant  output  4  one-hot registered grant; all-zero when idle.
- select  output  2  binary index of current or last owner; drives the mux select.
- busy  output  1  high when any grant bit is high.
- hold_expired  output  1  one-cycle pulse on the edge where a grant was preempted by the hold timer.

Behaviour:
- Reset (async assert, sync release):
  - grant=4'b0000, select=2'b00, busy=0, hold_expired=0.
  - last-owner pointer=3, so client 0 wins first; hold counter=0; state IDLE.
- States: IDLE, OWNED. All outputs are registered.
- Round-robin pick: search order is last+1, last+2, last+3, last (mod 4); the first set bit in the candidate vector wins.
- IDLE:
  - If req!=0, the next edge asserts grant[pick(req)], sets select to that index, updates last to it, clears the counter, and enters OWNED.
  - Latency from req sampled high to grant high is 1 cycle.
- OWNED, with owner o:
  - If req[o]=0 and other requests exist: the next edge hands over directly to pick(req) with no idle bubble, and the counter clears.
  - If req[o]=0 and no other requests: the next edge goes to IDLE, grant=0, and select keeps o (mux output stays stable).
  - If req[o]=1, counter=MAX_HOLD-1 and (req & ~onehot(o))!=0: preempt. The next edge grants pick(req & ~onehot(o)), hold_expired=1 for one cycle, and the counter clears.
  - If req[o]=1, counter=MAX_HOLD-1 and no other request: keep the grant; the counter saturates at MAX_HOLD-1.
  - Otherwise keep the grant; counter +1.
  - With MAX_HOLD=1 the counter is always at MAX_HOLD-1, so under contention the grant rotates every cycle.
- Client protocol:
  - Hold req until grant is seen.
  - Deassert req to release; grant falls 1 cycle after req drops.
  - A req deasserted before grant simply drops out of the next pick.
- Simultaneous events:
  - Owner release and preemption on the same edge: treated as release (hold_expired=0).
  - New requests arriving during OWNED are considered only at the next decision edge.
- Invariants: grant is always one-hot or zero; busy==|grant; when grant!=0, select equals the index of its set bit.
- Reset mid-grant: outputs clear immediately (asynchronously); an in-flight memory access is abandoned; clients must re-request after release.

Decomposition:
- Shared package mem_arb_pkg holds:
  - NUM_CLIENTS=4 and SEL_W=2.
  - Client index constants CLI_DISPLAY=0, CLI_ENGINE=1, CLI_LOADER=2, CLI_HOST=3.
  - State enum {ARB_IDLE, ARB_OWNED}.
- One combinational sub-module rr_pick_4:
  - Inputs: 4-bit candidate vector, 2-bit last pointer.
  - Outputs: valid, 2-bit index.
  - Instanced once; the candidate vector is req or req & ~onehot(owner), muxed by state.

Test Plan:
- Reset, then req=4'b0100 held: grant=4'b0100 one cycle later, select=2, busy=1. Drop req: next cycle grant=0, select stays 2.
- After reset, req=4'b1111 on the same edge: grant goes to client 0 first; each client releases after 2 cycles; handover order is 0,1,2,3,0 with no idle cycle between grants.
- MAX_HOLD=4, req[1] held forever, req[3] raised at cycle 2: grant[1] for exactly 4 cycles, then grant=4'b1000 with a hold_expired pulse. When client 3 releases, client 1 is regranted.
- MAX_HOLD=4, only req[2] held for 20 cycles: grant[2] is never dropped, hold_expired never pulses, and the counter saturates at 3.
- Owner drops req on the same edge its counter hits MAX_HOLD-1 while req[0] is pending: handover to client 0 with hold_expired=0.
- rst_n pulsed low mid-grant for less than one clock period: grant=0 and select=0 asynchronously. After release with req=4'b0010, the grant goes to client 1 one cycle later and last=1.
